branch_metric_gen: RTL

Branch-metric stage of the turbo decoder SISO, directly upstream of the alpha (forward state metric) recursion. It accepts one trellis step per cycle of systematic LLR, parity LLR and a-priori LLR. It computes the four registered, saturated branch metrics m00/m01/m10/m11 and frames each block with an init pulse (`state3`) and a last-step marker. The alpha stage loads its init values on `state3` and updates its state registers only on cycles with `m_valid` high.

---
 rtl/turbo_pkg.sv | 15 +
 rtl/bm_sat_half.sv | 27 ++
 rtl/branch_metric_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// Shared turbo-decoder SISO definitions: default widths, metric limit and the
// control FSM state type reused by later SISO control stages.
package turbo_pkg;

    localparam int W_DEF         = 16;
    localparam int FRAME_LEN_DEF = 40;
    localparam int MET_MAX       = 2 ** (W_DEF - 1) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } siso_state_t;

endpackage

// File: rtl/bm_sat_half.sv
// Halves a (W+2)-bit signed sum with floor rounding and clamps it symmetrically
// to +/-(2^(W-1)-1) so the caller can negate the result without overflow.
module bm_sat_half #(
    parameter int W = 16
) (
    input  logic signed [W+1:0] din,
    output logic signed [W-1:0] dout
);

    localparam logic signed [W+1:0] LIM_POS = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] LIM_NEG = -LIM_POS;

    logic signed [W+1:0] half;

    assign half = din >>> 1;

    always_comb begin
        if (half > LIM_POS) begin
            dout = LIM_POS[W-1:0];
        end else if (half < LIM_NEG) begin
            dout = LIM_NEG[W-1:0];
        end else begin
            dout = half[W-1:0];
        end
    end

endmodule

// File: rtl/branch_metric_gen.sv
// Branch-metric stage feeding the alpha recursion: frames each block with an
// init pulse, accepts one trellis step per cycle and registers saturated metrics.
module branch_metric_gen
    import turbo_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] ys,
    input  logic signed [W-1:0] yp,
    input  logic signed [W-1:0] la,
    output logic                state3,
    output logic signed [W-1:0] m00,
    output logic signed [W-1:0] m01,
    output logic signed [W-1:0] m10,
    output logic signed [W-1:0] m11,
    output logic                m_valid,
    output logic                m_last,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    siso_state_t         state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_inc;
    logic                in_ready_reg;
    logic                busy_reg;
    logic                state3_reg;
    logic                m_valid_reg;
    logic                m_last_reg;
    logic signed [W-1:0] m00_reg, m01_reg, m10_reg, m11_reg;

    logic signed [W+1:0] s_sum, sum11, sum10;
    logic signed [W-1:0] sat11, sat10;
    logic                transfer;

    // Two guard bits cover ys+la+/-yp for any pair of full-range inputs.
    assign s_sum = {{2{ys[W-1]}}, ys} + {{2{la[W-1]}}, la};
    assign sum11 = s_sum + {{2{yp[W-1]}}, yp};
    assign sum10 = s_sum - {{2{yp[W-1]}}, yp};

    bm_sat_half #(.W(W)) u_half11 (.din(sum11), .dout(sat11));
    bm_sat_half #(.W(W)) u_half10 (.din(sum10), .dout(sat10));

    assign transfer = in_valid && in_ready_reg;
    assign cnt_inc  = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            state3_reg   <= 1'b0;
            m_valid_reg  <= 1'b0;
            m_last_reg   <= 1'b0;
            m00_reg      <= '0;
            m01_reg      <= '0;
            m10_reg      <= '0;
            m11_reg      <= '0;
        end else begin
            state3_reg  <= (state_reg == INIT);
            m_valid_reg <= transfer;
            m_last_reg  <= transfer && (cnt_inc == LAST_CNT);

            // Bubbles carry zero metrics so stale values never leak downstream.
            if (transfer) begin
                m11_reg <= sat11;
                m10_reg <= sat10;
                m01_reg <= -sat10;
                m00_reg <= -sat11;
            end else begin
                m11_reg <= '0;
                m10_reg <= '0;
                m01_reg <= '0;
                m00_reg <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= INIT;
                        busy_reg  <= 1'b1;
                    end
                end
                INIT: begin
                    cnt_reg      <= '0;
                    state_reg    <= RUN;
                    in_ready_reg <= 1'b1;
                end
                RUN: begin
                    if (transfer) begin
                        cnt_reg <= cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_reg    <= IDLE;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_reg;
    assign busy     = busy_reg;
    assign state3   = state3_reg;
    assign m_valid  = m_valid_reg;
    assign m_last   = m_last_reg;
    assign m00      = m00_reg;
    assign m01      = m01_reg;
    assign m10      = m10_reg;
    assign m11      = m11_reg;

endmodule
